// File: rtl/aes_inv_cipher_ctrl.sv
// Iterative AES-128 inverse cipher: one round per clock over a single 128-bit state
// register, with round keys fetched by index from an external key-schedule store.

module aes_inv_mix_columns (
    input  logic [127:0] din,
    output logic [127:0] dout
);
    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Column bytes are rows 0..3, row 0 in the most significant byte.
    function automatic logic [31:0] mix_col(input logic [31:0] col);
        logic [7:0] a  [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [7:0] x2, x4, x8;
        for (int i = 0; i < 4; i++) begin
            a[i]  = col[8*(3-i) +: 8];
            x2    = xt(a[i]);
            x4    = xt(x2);
            x8    = xt(x4);
            m9[i] = x8 ^ a[i];
            mb[i] = x8 ^ x2 ^ a[i];
            md[i] = x8 ^ x4 ^ a[i];
            me[i] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    for (genvar c = 0; c < 4; c++) begin : g_col
        assign dout[32*(3-c) +: 32] = mix_col(din[32*(3-c) +: 32]);
    end
endmodule

module aes_inv_cipher_ctrl (
    input  logic         clk,
    input  logic         rst,
    input  logic         key_ready,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] ct_in,
    output logic [3:0]   rk_idx,
    input  logic [127:0] rk,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] pt_out,
    output logic         busy,
    output logic [1:0]   dbg_state
);
    // Handshakes: a transfer happens on a rising edge where valid and ready are both
    // high; a producer holds valid and its data stable until that edge.

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ROUND = 2'd1;
    localparam logic [1:0] FINAL = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    logic [1:0]   st;
    logic [3:0]   rnd;
    logic [127:0] state_q;
    logic [127:0] isr, isb, ark, imc;

    // Row r of the output takes the byte r columns to its left (rotate right by r).
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[8*(15-(4*c+r)) +: 8] = s[8*(15-(4*((c-r+4)%4)+r)) +: 8];
        return o;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int k = 0; k < 16; k++)
            o[8*(15-k) +: 8] = INV_SBOX[8*(255-int'(s[8*(15-k) +: 8])) +: 8];
        return o;
    endfunction

    assign isr = inv_shift_rows(state_q);
    assign isb = inv_sub_bytes(isr);
    assign ark = isb ^ rk;

    aes_inv_mix_columns u_imc (
        .din  (ark),
        .dout (imc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st      <= IDLE;
            rnd     <= 4'd0;
            state_q <= '0;
        end else begin
            case (st)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        state_q <= ct_in ^ rk;
                        rnd     <= 4'd9;
                        st      <= ROUND;
                    end
                end
                ROUND: begin
                    state_q <= imc;
                    rnd     <= rnd - 4'd1;
                    if (rnd == 4'd1) st <= FINAL;
                end
                FINAL: begin
                    state_q <= ark;
                    st      <= DONE;
                end
                DONE: begin
                    if (out_ready) st <= IDLE;
                end
                default: st <= IDLE;
            endcase
        end
    end

    // Key index depends on registered state only so the key store sees no input path.
    always_comb begin
        rk_idx = 4'd10;
        case (st)
            ROUND:   rk_idx = rnd;
            FINAL:   rk_idx = 4'd0;
            default: rk_idx = 4'd10;
        endcase
    end

    assign in_ready  = (st == IDLE) && key_ready;
    assign out_valid = (st == DONE);
    assign pt_out    = out_valid ? state_q : '0;
    assign busy      = (st != IDLE);
    assign dbg_state = st;
endmodule

// File: tb/tb_aes_inv_cipher_ctrl.sv
// Bench for aes_inv_cipher_ctrl: FIPS-197 vectors plus random blocks produced by a
// forward AES-128 model, so every expected plaintext is known before decryption.

module tb_aes_inv_cipher_ctrl;
    logic         clk;
    logic         rst;
    logic         key_ready;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] ct_in;
    logic [3:0]   rk_idx;
    logic [127:0] rk;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] pt_out;
    logic         busy;
    logic [1:0]   dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    logic [127:0] rk_sched [0:10];
    logic [127:0] exp_q [$];
    logic [3:0]   rk_log [$];

    logic [2047:0] sbox_tbl = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

    aes_inv_cipher_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .key_ready (key_ready),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ct_in     (ct_in),
        .rk_idx    (rk_idx),
        .rk        (rk),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pt_out    (pt_out),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    // Key store model: combinational read of the precomputed schedule.
    assign rk = (rk_idx <= 4'd10) ? rk_sched[rk_idx] : '0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- reference model: forward AES-128 ----------------
    function automatic logic [7:0] sbox(input logic [7:0] x);
        return sbox_tbl[2047 - 8*int'(x) -: 8];
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    task automatic key_expand(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] tmp;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {sbox(tmp[23:16]), sbox(tmp[15:8]), sbox(tmp[7:0]), sbox(tmp[31:24])}
                      ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int r = 0; r <= 10; r++) rk_sched[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] aes_enc(input logic [127:0] pt);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] o;
        for (int k = 0; k < 16; k++) s[k] = pt[127-8*k -: 8] ^ rk_sched[0][127-8*k -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int k = 0; k < 16; k++) t[k] = sbox(s[k]);
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++)
                    s[4*c+row] = t[4*((c+row)%4)+row];
            if (r != 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end
            end
            for (int k = 0; k < 16; k++) s[k] = s[k] ^ rk_sched[r][127-8*k -: 8];
        end
        for (int k = 0; k < 16; k++) o[127-8*k -: 8] = s[k];
        return o;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- driver tasks (entered 1 time unit after a rising edge) ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for out_valid, logging rk_idx for every cycle still in flight.
    task automatic wait_out(input string tag, input int max_cyc, output int lat);
        lat = 0;
        while (!out_valid && lat < max_cyc) begin
            rk_log.push_back(rk_idx);
            tick();
            lat++;
        end
        check({tag, "_out_valid"}, out_valid, 1);
    endtask

    task automatic decrypt_one(input logic [127:0] ct, input logic [127:0] pt, input string tag);
        int lat;
        ct_in     = ct;
        in_valid  = 1'b1;
        key_ready = 1'b1;
        out_ready = 1'b1;
        rk_log.delete();
        #1;
        check({tag, "_in_ready"}, in_ready, 1);
        rk_log.push_back(rk_idx);
        tick();
        in_valid = 1'b0;
        ct_in    = rand128();
        wait_out(tag, 30, lat);
        check({tag, "_latency"}, lat, 10);
        check({tag, "_pt"}, pt_out, pt);
        tick();
        check({tag, "_valid_drop"}, out_valid, 0);
        check({tag, "_pt_zero"}, pt_out, 0);
        check({tag, "_busy_idle"}, busy, 0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [127:0] pt2, ct2, cur_pt;
        int           lat, n_in, n_out, extra;
        logic         acc;

        rst = 1'b1; key_ready = 1'b0; in_valid = 1'b0; out_ready = 1'b0; ct_in = '0;
        key_expand(C1_KEY);

        // Reset values before any clock edge.
        #3;
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_rk_idx", rk_idx, 10);
        check("rst_pt_out", pt_out, 0);
        check("rst_in_ready", in_ready, 0);
        tick();
        @(negedge clk);
        rst = 1'b0;
        tick();

        // FIPS-197 C.1.
        decrypt_one(C1_CT, C1_PT, "c1");

        // Backpressure in DONE with a second block waiting.
        pt2 = rand128();
        ct2 = aes_enc(pt2);
        ct_in = C1_CT; in_valid = 1'b1; out_ready = 1'b0; key_ready = 1'b1;
        tick();
        ct_in = ct2;
        check("bp_in_ready_round", in_ready, 0);
        wait_out("bp", 30, lat);
        check("bp_latency", lat, 10);
        for (int i = 0; i < 5; i++) begin
            check("bp_hold_valid", out_valid, 1);
            check("bp_hold_pt", pt_out, C1_PT);
            check("bp_in_ready_done", in_ready, 0);
            check("bp_busy_done", busy, 1);
            tick();
        end
        out_ready = 1'b1;
        #1;
        check("bp_pt_at_hs", pt_out, C1_PT);
        tick();
        check("bp_after_hs_valid", out_valid, 0);
        check("bp_after_hs_busy", busy, 0);
        check("bp_after_hs_in_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        check("bp_second_accepted", busy, 1);
        wait_out("bp2", 30, lat);
        check("bp2_latency", lat, 10);
        check("bp2_pt", pt_out, pt2);
        tick();

        // key_ready low blocks acceptance.
        key_ready = 1'b0; in_valid = 1'b1; ct_in = C1_CT; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("kr_in_ready_low", in_ready, 0);
            tick();
            check("kr_busy_low", busy, 0);
        end
        key_ready = 1'b1;
        #1;
        check("kr_in_ready_rise", in_ready, 1);
        tick();
        in_valid = 1'b0;
        key_ready = 1'b0;
        check("kr_accepted", busy, 1);
        wait_out("kr", 30, lat);
        check("kr_latency", lat, 10);
        check("kr_pt", pt_out, C1_PT);
        tick();

        // Asynchronous reset mid-ROUND at rnd = 5.
        key_ready = 1'b1; in_valid = 1'b1; ct_in = C1_CT; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 20 && rk_idx != 4'd5; i++) tick();
        check("ar_reached_rnd5", rk_idx, 5);
        #3;
        rst = 1'b1;
        #1;
        check("ar_out_valid", out_valid, 0);
        check("ar_busy", busy, 0);
        check("ar_rk_idx", rk_idx, 10);
        check("ar_pt_out", pt_out, 0);
        tick();
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("ar_no_output", out_valid, 0);
        decrypt_one(C1_CT, C1_PT, "ar_c1");

        // FIPS-197 Appendix B with round-key index trace.
        key_expand(B_KEY);
        decrypt_one(B_CT, B_PT, "appb");
        check("appb_rk_log_len", rk_log.size(), 11);
        for (int i = 0; i < 11 && i < rk_log.size(); i++)
            check("appb_rk_idx", rk_log[i], 10 - i);

        // Back-to-back random blocks under a random key.
        key_expand(rand128());
        cur_pt   = rand128();
        ct_in    = aes_enc(cur_pt);
        in_valid = 1'b1;
        n_in = 0; n_out = 0;
        for (int cyc = 0; cyc < 2000 && n_out < 20; cyc++) begin
            out_ready = 1'($urandom_range(0, 1));
            key_ready = ($urandom_range(0, 7) != 0);
            #1;
            acc = in_valid && in_ready;
            if (busy) check("b2b_in_ready_busy", in_ready, 0);
            if (!out_valid) check("b2b_pt_zero", pt_out, 0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check("b2b_extra_output", out_valid, 0);
                else check("b2b_pt", pt_out, exp_q.pop_front());
                n_out++;
            end
            if (acc) begin
                exp_q.push_back(cur_pt);
                n_in++;
            end
            tick();
            if (acc) begin
                if (n_in < 20) begin
                    cur_pt = rand128();
                    ct_in  = aes_enc(cur_pt);
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        check("b2b_out_count", n_out, 20);
        check("b2b_queue_empty", exp_q.size(), 0);
        out_ready = 1'b1;
        extra = 0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid) extra++;
            tick();
        end
        check("b2b_no_duplicate", extra, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/aes_inv_cipher_ctrl.md
AES_INV_CIPHER_CTRL -- requirements
Module: aes_inv_cipher_ctrl

Interface
- REQ-001: Parameters: none; round count is fixed at 10 (AES-128).
- REQ-002: clk  input  1  single clock; all state updates on rising edge.
- REQ-003: rst  input  1  reset, asynchronous, active-high.
- REQ-004: key_ready  input  1  the round-key store holds a complete schedule.
- REQ-005: in_valid  input  1  ct_in is valid.
- REQ-006: in_ready  output  1  the block accepts ct_in this cycle.
- REQ-007: ct_in  input  128  ciphertext block.
- REQ-008: rk_idx  output  4  round-key index requested, range 0..10.
- REQ-009: rk  input  128  round key for rk_idx; combinational read, valid in the same cycle.
- REQ-010: out_valid  output  1  pt_out is valid.
- REQ-011: out_ready  input  1  the consumer accepts pt_out.
- REQ-012: pt_out  output  128  plaintext block.
- REQ-013: busy  output  1  a block is in flight (any state other than IDLE).

Function
- REQ-014: Byte order SHALL be: byte k = bits [8*(15-k)+:8]; column c = bytes 4c..4c+3; row r = byte index mod 4.
- REQ-015: The block SHALL hold a single 128-bit state register and instantiate the existing InvMixColumns module once, combinationally, on the round path.
- REQ-016: InvShiftRows SHALL rotate row r right by r columns; InvSubBytes SHALL use the inverse S-box; AddRoundKey SHALL XOR with rk.
- REQ-017: FSM states SHALL be IDLE, ROUND, FINAL and DONE, with a 4-bit round counter rnd.
- REQ-018: IDLE: in_ready = key_ready; rk_idx = 10; on in_valid & in_ready, state <= ct_in ^ rk, rnd <= 9, go to ROUND.
- REQ-019: ROUND: rk_idx = rnd; state <= InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ rk); rnd decrements; when rnd = 1, go to FINAL.
- REQ-020: FINAL: rk_idx = 0; state <= InvSubBytes(InvShiftRows(state)) ^ rk; go to DONE.
- REQ-021: DONE: out_valid = 1 and pt_out = state, both held stable until out_ready; on out_valid & out_ready, go to IDLE.
- REQ-022: Latency: acceptance at edge E SHALL yield out_valid high after edge E+10 (9 ROUND cycles plus 1 FINAL cycle); throughput is at most one block per 12 cycles.
- REQ-023: in_ready SHALL be 0 in every state except IDLE; in_valid outside IDLE SHALL be ignored and not queued.
- REQ-024: key_ready low in IDLE SHALL block acceptance even when in_valid = 1; key_ready changes mid-operation SHALL be ignored.
- REQ-025: rk_idx SHALL decode from registered state only, with no combinational path from any input.
- REQ-026: out_ready asserted while not in DONE SHALL have no effect.
- REQ-027: pt_out SHALL be 0 whenever out_valid = 0.

Reset
- REQ-028: While rst = 1, regardless of clk: state IDLE, rnd = 0, state register = 0, out_valid = 0, pt_out = 0, busy = 0, rk_idx = 10.
- REQ-029: rst asserted in any state SHALL abort the block in flight with no output produced; the first edge after release SHALL behave as IDLE.

Verification
- REQ-030: FIPS-197 C.1: rk schedule for key 000102030405060708090a0b0c0d0e0f, ct_in = 69c4e0d86a7b0430d8cdb78070b4c55a, out_ready = 1 -> pt_out = 00112233445566778899aabbccddeeff, out_valid exactly 10 edges after acceptance.
- REQ-031: FIPS-197 Appendix B: key 2b7e151628aed2a6abf7158809cf4f3c, ct_in = 3925841d02dc09fbdc118597196a0b32 -> pt_out = 3243f6a8885a308d313198a2e0370734; rk_idx sequence 10,9,...,1,0 observed.
- REQ-032: Backpressure: out_ready = 0 for 5 cycles in DONE -> out_valid and pt_out stable throughout; in_ready = 0; a second in_valid is not accepted until the cycle after the handshake.
- REQ-033: key_ready = 0 with in_valid = 1 for 3 cycles -> in_ready = 0, busy = 0; key_ready rising -> acceptance that cycle.
- REQ-034: rst pulsed (asynchronous, mid-cycle) during ROUND at rnd = 5 -> out_valid = 0, busy = 0, rk_idx = 10 immediately; a fresh C.1 block afterwards decrypts correctly.
- REQ-035: Back-to-back: 20 random blocks checked against a reference model, with in_valid always high and random out_ready -> all outputs match, in order, with none dropped or duplicated.
